// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

    localparam int NUM_ARCH_REGS = 32;
    localparam int REG_IDX_W     = $clog2(NUM_ARCH_REGS);
    localparam int XLEN          = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // One writeback request as seen by the arbiter.
    typedef struct packed {
        logic            valid;
        reg_idx_t        rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

    // Fixed requester slots.
    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;

    // Width of an index into n requesters; never zero so a single-port build still elaborates.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus: one valid/ready/rd/data lane per requester.
interface regfile_wb_arbiter_if
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
);
    logic     [NUM_REQ-1:0]           req_valid;
    reg_idx_t [NUM_REQ-1:0]           req_rd;
    logic     [NUM_REQ-1:0][XLEN-1:0] req_data;
    logic     [NUM_REQ-1:0]           req_ready;

    // Requester side drives results and observes the grant.
    modport master (
        output req_valid, req_rd, req_data,
        input  req_ready
    );

    // Arbiter side consumes results and drives the grant.
    modport slave (
        input  req_valid, req_rd, req_data,
        output req_ready
    );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Generic round-robin arbiter: scans from ptr upward, wrapping, and grants
// the first active request. Purely combinational; the caller owns the pointer.
module rr_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int PTR_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               grant_valid
);

    int idx;

    // Priority scan starting at ptr; the first hit suppresses all later ones.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(ptr) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_valid && req[idx]) begin
                grant[idx]  = 1'b1;
                grant_idx   = PTR_W'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter with a per-register busy scoreboard.
// Requesters compete round-robin for the single write port; the winner is
// registered and written one cycle later. The scoreboard tracks issued but
// not yet committed destinations for RAW detection and WAW stalls.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int NUM_REGS = NUM_ARCH_REGS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  wb,
    output logic                 rf_we,
    output reg_idx_t             rf_rd,
    output logic [XLEN-1:0]      rf_wdata,
    input  logic                 iss_valid,
    input  reg_idx_t             iss_rd,
    output logic                 iss_ready,
    input  reg_idx_t             chk_rs1,
    input  reg_idx_t             chk_rs2,
    output logic                 hazard_rs1,
    output logic                 hazard_rs2,
    output logic [NUM_REGS-1:0]  busy
);

    localparam int PTR_W = idx_width(NUM_REQ);

    wb_req_t              reqs [NUM_REQ];
    wb_req_t              granted;
    logic [NUM_REQ-1:0]   req_vec;
    logic [NUM_REQ-1:0]   grant;
    logic [PTR_W-1:0]     grant_idx;
    logic                 grant_valid;

    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                 rf_we_q, rf_we_d;
    reg_idx_t             rf_rd_q, rf_rd_d;
    logic [XLEN-1:0]      rf_wdata_q, rf_wdata_d;
    logic [NUM_REGS-1:0]  busy_q, busy_d;
    logic                 iss_fire;

    // Collect the interface lanes into request records.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            reqs[i].valid = wb.req_valid[i];
            reqs[i].rd    = wb.req_rd[i];
            reqs[i].data  = wb.req_data[i];
            req_vec[i]    = wb.req_valid[i];
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req         (req_vec),
        .ptr         (rr_ptr_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign wb.req_ready = grant;

    // Pick the winning record and advance the pointer just past the winner.
    always_comb begin
        granted  = grant_valid ? reqs[grant_idx] : '0;
        rr_ptr_d = rr_ptr_q;
        if (grant_valid) begin
            rr_ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + PTR_W'(1);
        end
    end

    // Output stage: x0 results complete the handshake but never write.
    always_comb begin
        rf_we_d    = granted.valid && (granted.rd != '0);
        rf_rd_d    = granted.valid ? granted.rd   : rf_rd_q;
        rf_wdata_d = granted.valid ? granted.data : rf_wdata_q;
    end

    // Scoreboard update: clear on commit, then set on issue so a same-edge set wins.
    always_comb begin
        iss_fire = iss_valid && iss_ready && (iss_rd != '0);
        busy_d   = busy_q;
        if (rf_we_q) begin
            busy_d[rf_rd_q] = 1'b0;
        end
        if (iss_fire) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Hazard and issue checks read the registered scoreboard only (no bypass).
    always_comb begin
        iss_ready  = !busy_q[iss_rd];
        hazard_rs1 = busy_q[chk_rs1];
        hazard_rs2 = busy_q[chk_rs2];
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value regardless of statement order.
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
            // NOTE: the whole scoreboard is cleared here; a stale busy bit
            // after reset would stall issue of that register forever.
            busy_q     <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
            busy_q     <= busy_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_rd    = rf_rd_q;
    assign rf_wdata = rf_wdata_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a directed vector table,
// randomized traffic against a reference model, and a mid-operation reset.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int NR = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            rf_we;
    reg_idx_t        rf_rd;
    logic [31:0]     rf_wdata;
    logic            iss_valid;
    reg_idx_t        iss_rd;
    logic            iss_ready;
    reg_idx_t        chk_rs1, chk_rs2;
    logic            hazard_rs1, hazard_rs2;
    logic [31:0]     busy;

    int n_vec = 0;
    int n_err = 0;

    regfile_wb_arbiter_if #(.NUM_REQ(NR)) bus ();

    regfile_wb_arbiter #(.NUM_REQ(NR), .NUM_REGS(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb         (bus),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_wdata   (rf_wdata),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .iss_ready  (iss_ready),
        .chk_rs1    (chk_rs1),
        .chk_rs2    (chk_rs2),
        .hazard_rs1 (hazard_rs1),
        .hazard_rs2 (hazard_rs2),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0]  vld;
        reg_idx_t    rd0;
        reg_idx_t    rd1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        iv;
        reg_idx_t    ird;
        reg_idx_t    rs1;
        logic [1:0]  e_rdy;
        logic        e_we;
        reg_idx_t    e_rd;
        logic [31:0] e_wd;
        logic        e_issr;
        logic        e_hz;
        logic [31:0] e_busy;
    } vec_t;

    vec_t tbl [17];

    task automatic drive_idle();
        bus.req_valid = '0;
        bus.req_rd    = '0;
        bus.req_data  = '0;
        iss_valid     = 1'b0;
        iss_rd        = '0;
        chk_rs1       = '0;
        chk_rs2       = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Reference model state, kept as plain spec-level quantities.
    int          m_ptr;
    logic [31:0] m_busy;
    logic        m_we;
    reg_idx_t    m_rd;
    logic [31:0] m_wd;

    task automatic model_reset();
        m_ptr  = 0;
        m_busy = '0;
        m_we   = 1'b0;
        m_rd   = '0;
        m_wd   = '0;
    endtask

    initial begin
        logic [31:0] nb;
        int          g;
        logic [1:0]  e_rdy;
        logic        e_issr;

        // Directed table: each row is one cycle, checked mid-cycle.
        //          vld    rd0 rd1 d0            d1            iv  ird rs1   rdy    we   rd  wd            issr hz   busy
        tbl[0]  = '{2'b00, 0,  0,  32'h0,        32'h0,        0,  0,  0,    2'b00, 0,   0,  32'h0,        1,   0,   32'h0};
        tbl[1]  = '{2'b01, 5,  0,  32'hDEADBEEF, 32'h0,        0,  0,  0,    2'b01, 0,   0,  32'h0,        1,   0,   32'h0};
        tbl[2]  = '{2'b00, 0,  0,  32'h0,        32'h0,        0,  0,  0,    2'b00, 1,   5,  32'hDEADBEEF, 1,   0,   32'h0};
        tbl[3]  = '{2'b00, 0,  0,  32'h0,        32'h0,        0,  0,  0,    2'b00, 0,   5,  32'hDEADBEEF, 1,   0,   32'h0};
        tbl[4]  = '{2'b11, 3,  7,  32'h33333333, 32'h77777777, 0,  0,  0,    2'b10, 0,   5,  32'hDEADBEEF, 1,   0,   32'h0};
        tbl[5]  = '{2'b11, 3,  7,  32'h33333333, 32'h77777777, 0,  0,  0,    2'b01, 1,   7,  32'h77777777, 1,   0,   32'h0};
        tbl[6]  = '{2'b11, 3,  7,  32'h33333333, 32'h77777777, 0,  0,  0,    2'b10, 1,   3,  32'h33333333, 1,   0,   32'h0};
        tbl[7]  = '{2'b11, 3,  7,  32'h33333333, 32'h77777777, 0,  0,  0,    2'b01, 1,   7,  32'h77777777, 1,   0,   32'h0};
        tbl[8]  = '{2'b00, 0,  0,  32'h0,        32'h0,        1,  9,  9,    2'b00, 1,   3,  32'h33333333, 1,   0,   32'h0};
        tbl[9]  = '{2'b10, 0,  9,  32'h0,        32'h1234,     1,  9,  9,    2'b10, 0,   3,  32'h33333333, 0,   1,   32'h200};
        tbl[10] = '{2'b00, 0,  0,  32'h0,        32'h0,        0,  0,  9,    2'b00, 1,   9,  32'h1234,     1,   1,   32'h200};
        tbl[11] = '{2'b00, 0,  0,  32'h0,        32'h0,        0,  9,  9,    2'b00, 0,   9,  32'h1234,     1,   0,   32'h0};
        tbl[12] = '{2'b01, 4,  0,  32'h44,       32'h0,        0,  0,  4,    2'b01, 0,   9,  32'h1234,     1,   0,   32'h0};
        tbl[13] = '{2'b00, 0,  0,  32'h0,        32'h0,        1,  4,  4,    2'b00, 1,   4,  32'h44,       1,   0,   32'h0};
        tbl[14] = '{2'b00, 0,  0,  32'h0,        32'h0,        0,  4,  4,    2'b00, 0,   4,  32'h44,       0,   1,   32'h10};
        tbl[15] = '{2'b10, 0,  0,  32'h0,        32'hAA,       0,  0,  4,    2'b10, 0,   4,  32'h44,       1,   1,   32'h10};
        tbl[16] = '{2'b00, 0,  0,  32'h0,        32'h0,        0,  0,  4,    2'b00, 0,   0,  32'hAA,       1,   1,   32'h10};

        // Reset state while rst_n is still low.
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_rf_we", 64'(rf_we), 64'd0);
        check("reset_rf_rd", 64'(rf_rd), 64'd0);
        check("reset_rf_wdata", 64'(rf_wdata), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int r = 0; r < 17; r++) begin
            bus.req_valid   = tbl[r].vld;
            bus.req_rd[0]   = tbl[r].rd0;
            bus.req_rd[1]   = tbl[r].rd1;
            bus.req_data[0] = tbl[r].d0;
            bus.req_data[1] = tbl[r].d1;
            iss_valid       = tbl[r].iv;
            iss_rd          = tbl[r].ird;
            chk_rs1         = tbl[r].rs1;
            chk_rs2         = tbl[r].rs1;
            @(negedge clk);
            check($sformatf("tbl%0d_req_ready", r), 64'(bus.req_ready), 64'(tbl[r].e_rdy));
            check($sformatf("tbl%0d_rf_we", r), 64'(rf_we), 64'(tbl[r].e_we));
            check($sformatf("tbl%0d_rf_rd", r), 64'(rf_rd), 64'(tbl[r].e_rd));
            check($sformatf("tbl%0d_rf_wdata", r), 64'(rf_wdata), 64'(tbl[r].e_wd));
            check($sformatf("tbl%0d_iss_ready", r), 64'(iss_ready), 64'(tbl[r].e_issr));
            check($sformatf("tbl%0d_hazard_rs1", r), 64'(hazard_rs1), 64'(tbl[r].e_hz));
            check($sformatf("tbl%0d_hazard_rs2", r), 64'(hazard_rs2), 64'(tbl[r].e_hz));
            check($sformatf("tbl%0d_busy", r), 64'(busy), 64'(tbl[r].e_busy));
            @(posedge clk);
            #1;
        end

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 400; c++) begin
            bus.req_valid = 2'($urandom_range(0, 3));
            for (int i = 0; i < NR; i++) begin
                bus.req_rd[i]   = reg_idx_t'($urandom_range(0, 7));
                bus.req_data[i] = $urandom;
            end
            iss_valid = 1'($urandom_range(0, 1));
            iss_rd    = reg_idx_t'($urandom_range(0, 7));
            chk_rs1   = reg_idx_t'($urandom_range(0, 7));
            chk_rs2   = reg_idx_t'($urandom_range(0, 7));
            @(negedge clk);

            g = -1;
            for (int k = 0; k < NR; k++) begin
                int i;
                i = (m_ptr + k) % NR;
                if (g < 0 && bus.req_valid[i]) g = i;
            end
            e_rdy  = (g < 0) ? 2'b00 : 2'(1 << g);
            e_issr = (iss_rd == 0) || !m_busy[iss_rd];

            check("rnd_req_ready", 64'(bus.req_ready), 64'(e_rdy));
            check("rnd_rf_we", 64'(rf_we), 64'(m_we));
            check("rnd_rf_rd", 64'(rf_rd), 64'(m_rd));
            check("rnd_rf_wdata", 64'(rf_wdata), 64'(m_wd));
            check("rnd_busy", 64'(busy), 64'(m_busy));
            check("rnd_iss_ready", 64'(iss_ready), 64'(e_issr));
            check("rnd_hazard_rs1", 64'(hazard_rs1), 64'(m_busy[chk_rs1]));
            check("rnd_hazard_rs2", 64'(hazard_rs2), 64'(m_busy[chk_rs2]));

            nb = m_busy;
            if (m_we) nb[m_rd] = 1'b0;
            if (iss_valid && e_issr && iss_rd != 0) nb[iss_rd] = 1'b1;
            m_busy = nb;
            if (g >= 0) begin
                m_we  = (bus.req_rd[g] != 0);
                m_rd  = bus.req_rd[g];
                m_wd  = bus.req_data[g];
                m_ptr = (g + 1) % NR;
            end else begin
                m_we = 1'b0;
            end
            @(posedge clk);
            #1;
        end

        // Reset mid-operation: fill the scoreboard, leave both requests pending, pulse reset.
        do_reset();
        for (int r = 1; r < 32; r++) begin
            iss_valid = 1'b1;
            iss_rd    = reg_idx_t'(r);
            @(posedge clk);
            #1;
        end
        iss_valid = 1'b0;
        iss_rd    = '0;
        check("full_busy", 64'(busy), 64'hFFFF_FFFE);
        bus.req_valid   = 2'b11;
        bus.req_rd[REQ_ALU]   = 5'd1;
        bus.req_rd[REQ_LSU]   = 5'd2;
        bus.req_data[REQ_ALU] = 32'hA1A1_A1A1;
        bus.req_data[REQ_LSU] = 32'hB2B2_B2B2;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_rf_we", 64'(rf_we), 64'd0);
        check("midrst_first_grant", 64'(bus.req_ready), 64'b01);
        @(posedge clk);
        #1;
        check("midrst_wb_rf_we", 64'(rf_we), 64'd1);
        check("midrst_wb_rf_rd", 64'(rf_rd), 64'd1);
        check("midrst_wb_rf_wdata", 64'(rf_wdata), 64'hA1A1_A1A1);
        check("midrst_second_grant", 64'(bus.req_ready), 64'b10);
        drive_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
